hilo_pipe_regs: RTL and testbench

- Clocked, parametrised successor to the ready-edge HI/LO latch.
- Holds the {HI, LO} pair written by the multiply/divide unit and by MTHI/MTLO.
- Tracks an outstanding mul/div operation and generates pipeline stall for MFHI/MFLO/MTHI/MTLO issued while a result is pending.
- Sits between the ID/EX stage and the iterative mul/div unit.

---
 rtl/hilo_pipe_regs.sv | 112 +++++++++++
 tb/tb_hilo_pipe_regs.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_pipe_regs.sv
// HI/LO register pair with mul/div pending tracking and MF/MT stall generation.
// Optional accumulate mode (MADD/MSUB) is enabled by defining HILO_ACC_EN.
module hilo_pipe_regs #(
  parameter int DATA_BITS = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   md_start,
  input  logic                   md_flush,
  input  logic                   md_valid,
  input  logic [2*DATA_BITS-1:0] md_result,
  input  logic                   mt_we_hi,
  input  logic                   mt_we_lo,
  input  logic [DATA_BITS-1:0]   mt_data,
  input  logic                   mf_req,
`ifdef HILO_ACC_EN
  input  logic [1:0]             acc_op,
`endif
  output logic [DATA_BITS-1:0]   lo,
  output logic [DATA_BITS-1:0]   hi,
  output logic                   busy,
  output logic                   stall
);

  localparam int W2 = 2 * DATA_BITS;

  typedef enum logic {S_IDLE = 1'b0, S_PENDING = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W2-1:0]   r_hilo;
  logic [W2-1:0]   w_result_val;
  logic            w_result_we;
  logic            w_mt_ok;
  logic            w_start_accept;
  logic            w_stall;

  assign w_result_we    = (r_state == S_PENDING) && md_valid && !md_flush;
  assign w_mt_ok        = (r_state == S_IDLE);
  // A start is taken from IDLE, or back-to-back in the cycle the previous result lands.
  assign w_start_accept = md_start && !md_flush && ((r_state == S_IDLE) || md_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (md_start && !md_flush) w_state_nxt = S_PENDING;
      end
      S_PENDING: begin
        if (md_flush)      w_state_nxt = S_IDLE;
        else if (md_valid) w_state_nxt = md_start ? S_PENDING : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_stall = 1'b0;
    if (r_state == S_PENDING) w_stall = mf_req || mt_we_hi || mt_we_lo;
  end

  assign busy  = (r_state == S_PENDING);
  assign stall = w_stall;

`ifdef HILO_ACC_EN
  logic [1:0] r_acc_op;

  function automatic logic [W2-1:0] f_acc(input logic [1:0] op,
                                          input logic [W2-1:0] cur,
                                          input logic [W2-1:0] res);
    case (op)
      2'b01:   f_acc = cur + res;
      2'b10:   f_acc = cur - res;
      default: f_acc = res;
    endcase
  endfunction

  // The op kind belongs to the outstanding operation, so it dies with a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_acc_op <= 2'b00;
    else if (md_flush)       r_acc_op <= 2'b00;
    else if (w_start_accept) r_acc_op <= acc_op;
  end

  assign w_result_val = f_acc(r_acc_op, r_hilo, md_result);
`else
  logic w_unused_start;
  assign w_unused_start = w_start_accept;
  assign w_result_val   = md_result;
`endif

  // A landing result wins; MT writes are only honoured while IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hilo <= '0;
    end else if (w_result_we) begin
      r_hilo <= w_result_val;
    end else if (w_mt_ok) begin
      if (mt_we_hi) r_hilo[W2-1:DATA_BITS] <= mt_data;
      if (mt_we_lo) r_hilo[DATA_BITS-1:0]  <= mt_data;
    end
  end

  assign hi = r_hilo[W2-1:DATA_BITS];
  assign lo = r_hilo[DATA_BITS-1:0];

endmodule

// File: tb/tb_hilo_pipe_regs.sv
// Scoreboard bench for hilo_pipe_regs: driver pushes expected outputs, a negedge monitor checks them.
module tb_hilo_pipe_regs;

  localparam int DB = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          md_start, md_flush, md_valid;
  logic [63:0]   md_result;
  logic          mt_we_hi, mt_we_lo;
  logic [DB-1:0] mt_data;
  logic          mf_req;
`ifdef HILO_ACC_EN
  logic [1:0]    acc_op;
`endif
  logic [DB-1:0] lo, hi;
  logic          busy, stall;

  always #5 clk = ~clk;

  hilo_pipe_regs #(.DATA_BITS(DB)) dut (
    .clk(clk), .rst_n(rst_n),
    .md_start(md_start), .md_flush(md_flush), .md_valid(md_valid), .md_result(md_result),
    .mt_we_hi(mt_we_hi), .mt_we_lo(mt_we_lo), .mt_data(mt_data), .mf_req(mf_req),
`ifdef HILO_ACC_EN
    .acc_op(acc_op),
`endif
    .lo(lo), .hi(hi), .busy(busy), .stall(stall)
  );

  typedef struct packed {
    logic [63:0] hilo;
    logic        busy;
    logic        stall;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: architectural HI:LO value, whether an op is outstanding, its op kind.
  logic [63:0] m_hilo;
  bit          m_pend;
  logic [1:0]  m_acc;

  function automatic logic [63:0] m_apply(input logic [1:0] op, input logic [63:0] cur,
                                          input logic [63:0] res);
    if (op == 2'b01)      return cur + res;
    else if (op == 2'b10) return cur - res;
    else                  return res;
  endfunction

  task automatic cyc(input string nm, input bit ms, input bit mf, input bit mv,
                     input logic [63:0] res, input bit whi, input bit wlo,
                     input logic [31:0] d, input bit rq, input logic [1:0] aop);
    exp_t e;
    logic [1:0] eff_aop;
    @(posedge clk); #1;
    rst_n = 1'b1;
    md_start = ms; md_flush = mf; md_valid = mv; md_result = res;
    mt_we_hi = whi; mt_we_lo = wlo; mt_data = d; mf_req = rq;
`ifdef HILO_ACC_EN
    acc_op  = aop;
    eff_aop = aop;
`else
    eff_aop = 2'b00;
`endif
    e.hilo  = m_hilo;
    e.busy  = m_pend;
    e.stall = m_pend && (rq || whi || wlo);
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (m_pend) begin
      if (mf) begin
        m_pend = 0;
        m_acc  = 2'b00;
      end else if (mv) begin
        m_hilo = m_apply(m_acc, m_hilo, res);
        m_pend = ms;
        if (ms) m_acc = eff_aop;
      end
    end else begin
      if (whi) m_hilo[63:32] = d;
      if (wlo) m_hilo[31:0]  = d;
      if (ms && !mf) begin
        m_pend = 1;
        m_acc  = eff_aop;
      end
    end
  endtask

  task automatic idle(input string nm);
    cyc(nm, 0, 0, 0, 64'h0, 0, 0, 32'h0, 0, 2'b00);
  endtask

  // Reset is asserted mid-cycle, so the check lands before any clock edge.
  task automatic do_reset(input string nm);
    exp_t e;
    @(posedge clk); #1;
    rst_n = 1'b0;
    md_start = 0; md_flush = 0; md_valid = 0; md_result = '0;
    mt_we_hi = 0; mt_we_lo = 0; mt_data = '0; mf_req = 0;
    m_hilo = '0; m_pend = 0; m_acc = 2'b00;
    e.hilo = '0; e.busy = 1'b0; e.stall = 1'b0;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  exp_t  mon_e;
  string mon_n;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      checks++;
      if ({hi, lo} !== mon_e.hilo || busy !== mon_e.busy || stall !== mon_e.stall) begin
        errors++;
        $display("FAIL %s: got hilo=%h busy=%b stall=%b, expected hilo=%h busy=%b stall=%b",
                 mon_n, {hi, lo}, busy, stall, mon_e.hilo, mon_e.busy, mon_e.stall);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    md_start = 0; md_flush = 0; md_valid = 0; md_result = '0;
    mt_we_hi = 0; mt_we_lo = 0; mt_data = '0; mf_req = 0;
`ifdef HILO_ACC_EN
    acc_op = 2'b00;
`endif
    m_hilo = '0; m_pend = 0; m_acc = 2'b00;

    do_reset("reset");
    idle("post_reset");

    // Result arrives three cycles after the start.
    cyc("start", 1, 0, 0, 64'h0, 0, 0, 32'h0, 0, 2'b00);
    idle("pend1");
    idle("pend2");
    cyc("result", 0, 0, 1, 64'hDEADBEEF_12345678, 0, 0, 32'h0, 0, 2'b00);
    idle("result_visible");

    // MF while pending stalls until the result lands, then reads it.
    cyc("mf_start", 1, 0, 0, 64'h0, 0, 0, 32'h0, 0, 2'b00);
    cyc("mf_stall1", 0, 0, 0, 64'h0, 0, 0, 32'h0, 1, 2'b00);
    cyc("mf_stall2", 0, 0, 1, 64'hCAFEF00D_87654321, 0, 0, 32'h0, 1, 2'b00);
    cyc("mf_read", 0, 0, 0, 64'h0, 0, 0, 32'h0, 1, 2'b00);

    // Flush discards a same-cycle result.
    cyc("fl_start", 1, 0, 0, 64'h0, 0, 0, 32'h0, 0, 2'b00);
    idle("fl_pend");
    cyc("fl_valid", 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 32'h0, 0, 2'b00);
    idle("fl_after");
    cyc("valid_idle", 0, 0, 1, 64'h1111_2222_3333_4444, 0, 0, 32'h0, 0, 2'b00);
    idle("valid_idle_after");

    // MT writes in IDLE, then blocked in PENDING.
    cyc("mt_idle", 0, 0, 0, 64'h0, 1, 1, 32'hA5A5A5A5, 0, 2'b00);
    cyc("mt_start", 1, 0, 0, 64'h0, 0, 0, 32'h0, 0, 2'b00);
    cyc("mt_pend", 0, 0, 0, 64'h0, 1, 1, 32'h5A5A5A5A, 0, 2'b00);
    cyc("mt_with_valid", 0, 0, 1, 64'h0123_4567_89AB_CDEF, 0, 1, 32'h5A5A5A5A, 0, 2'b00);
    cyc("mt_retry", 0, 0, 0, 64'h0, 0, 1, 32'h5A5A5A5A, 0, 2'b00);
    idle("mt_retry_after");

    // Back-to-back op, and start ignored while pending.
    cyc("b2b_start", 1, 0, 0, 64'h0, 0, 0, 32'h0, 0, 2'b00);
    cyc("b2b_ignored", 1, 0, 0, 64'h0, 0, 0, 32'h0, 0, 2'b00);
    cyc("b2b_valid", 1, 0, 1, 64'h0000_0001_0000_0002, 0, 0, 32'h0, 0, 2'b00);
    cyc("b2b_valid2", 0, 0, 1, 64'h0000_0003_0000_0004, 0, 0, 32'h0, 0, 2'b00);
    idle("b2b_done");

    // Reset while pending discards the op.
    cyc("rst_start", 1, 0, 0, 64'h0, 0, 0, 32'h0, 0, 2'b00);
    idle("rst_pend");
    do_reset("rst_mid_pend");
    cyc("rst_late_valid", 0, 0, 1, 64'h1, 0, 0, 32'h0, 0, 2'b00);
    idle("rst_hilo_zero");

`ifdef HILO_ACC_EN
    cyc("acc_set_hi", 0, 0, 0, 64'h0, 1, 0, 32'h0000_0000, 0, 2'b00);
    cyc("acc_set_lo", 0, 0, 0, 64'h0, 0, 1, 32'hFFFF_FFFF, 0, 2'b00);
    cyc("acc_madd", 1, 0, 0, 64'h0, 0, 0, 32'h0, 0, 2'b01);
    cyc("acc_madd_v", 0, 0, 1, 64'h1, 0, 0, 32'h0, 0, 2'b00);
    cyc("acc_msub", 1, 0, 0, 64'h0, 0, 0, 32'h0, 0, 2'b10);
    cyc("acc_msub_v", 0, 0, 1, 64'h0000_0001_0000_0001, 0, 0, 32'h0, 0, 2'b00);
    cyc("acc_op11", 1, 0, 0, 64'h0, 0, 0, 32'h0, 0, 2'b11);
    cyc("acc_op11_v", 0, 0, 1, 64'h0000_0002_0000_0003, 0, 0, 32'h0, 0, 2'b00);
    idle("acc_done");
`endif

    for (int i = 0; i < 600; i++) begin
      if (($urandom % 100) == 0) do_reset("rand_rst");
      else cyc("rand", ($urandom % 4) == 0, ($urandom % 16) == 0, ($urandom % 3) == 0,
               {$urandom, $urandom}, ($urandom % 6) == 0, ($urandom % 6) == 0,
               $urandom, ($urandom % 3) == 0, 2'($urandom % 4));
    end
    idle("tail");

    @(posedge clk); #1;
    @(posedge clk); #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
